and_reg_tester: RTL and testbench

AND_REG_TESTER -- requirements
Module: and_reg_tester

---
 rtl/and_reg_tester.sv | 154 +++++++++++++++
 tb/tb_and_reg_tester.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/and_reg_tester.sv
// ---------------------------------------------------------------------------
// and_reg_tester
//
// Purpose: drives all four input combinations into a registered AND unit under
// test. For each combination it waits for the unit's one-cycle capture, then
// compares the unit's q against the expected AND of the vector. It reports a
// saturating mismatch count and a pass flag when the sweep ends.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level request for a sweep, sampled only while idle
//   q          in   registered AND output of the unit under test
//   a1, a2     out  registered stimulus bits ({a1,a2} = 00, 01, 10, 11)
//   busy       out  high whenever the sweep FSM is not idle
//   done       out  one-cycle pulse in the final cycle of a sweep
//   pass       out  1 when the sweep ended with zero mismatches
//   err_count  out  mismatches since the last accepted start (saturating)
//
// Configuration macro: AND_TESTER_LOOP_EN
//   When defined, a held start makes sweeps run back to back from DONE. The
//   error count accumulates across those looped sweeps.
// ---------------------------------------------------------------------------
module and_reg_tester #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q,
  output logic             a1,
  output logic             a2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned VEC_W = 2;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q,   vec_d;
  logic [VEC_W-1:0] a_q,     a_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic             pass_q,  pass_d;
  logic             busy_q;
  logic             done_q;
  logic             exp_c;

  // Expected unit output for the vector currently under check
  assign exp_c = vec_q[1] & vec_q[0];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    a_d     = a_q;
    err_d   = err_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end

      DRIVE: begin
        a_d     = vec_q;
        state_d = WAIT;
      end

      // The unit under test captures a1&a2 on the edge leaving this state
      WAIT: begin
        state_d = CHECK;
      end

      CHECK: begin
        if ((q != exp_c) && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          // Result is decided with the final check folded in, so pass is
          // valid alongside the done pulse
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = DRIVE;
        end
      end

      DONE: begin
`ifdef AND_TESTER_LOOP_EN
        if (start) begin
          state_d = DRIVE;
          vec_d   = '0;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done are precomputed from the next state
  // so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      a_q     <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign a1        = a_q[1];
  assign a2        = a_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_and_reg_tester.sv
// ---------------------------------------------------------------------------
// tb_and_reg_tester
//
// Directed bench for and_reg_tester. A behavioural AND register (correct,
// stuck-at-0 or stuck-at-1) feeds q of the main ERR_W=8 instance. Two narrow
// instances (ERR_W=2 and ERR_W=1) see a unit stuck at 1 and exercise
// counter saturation.
// ---------------------------------------------------------------------------
module tb_and_reg_tester;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q_m   = 1'b0;
  int   mode  = 0;  // 0: correct AND, 1: stuck 0, 2: stuck 1

  logic       a1, a2, busy, done, pass;
  logic [7:0] err_count;

  logic       a1_w2, a2_w2, busy_w2, done_w2, pass_w2;
  logic [1:0] err_w2;
  logic       a1_w1, a2_w1, busy_w1, done_w1, pass_w1;
  logic [0:0] err_w1;

  int n_vec = 0;
  int n_err = 0;

`ifdef AND_TESTER_LOOP_EN
  localparam int PERIOD = 13;
`else
  localparam int PERIOD = 14;
`endif

  always #5 clk = ~clk;

  // Behavioural registered AND unit, with selectable stuck faults
  always @(posedge clk) begin
    case (mode)
      0:       q_m <= a1 & a2;
      1:       q_m <= 1'b0;
      default: q_m <= 1'b1;
    endcase
  end

  and_reg_tester #(.ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q_m),
    .a1(a1), .a2(a2), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count)
  );

  and_reg_tester #(.ERR_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .q(1'b1),
    .a1(a1_w2), .a2(a2_w2), .busy(busy_w2), .done(done_w2), .pass(pass_w2),
    .err_count(err_w2)
  );

  and_reg_tester #(.ERR_W(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start), .q(1'b1),
    .a1(a1_w1), .a2(a2_w1), .busy(busy_w1), .done(done_w1), .pass(pass_w1),
    .err_count(err_w1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then cycle-by-cycle checks through the 13-cycle sweep
  task automatic sweep(input string tag, input int exp_err, input logic exp_pass,
                       input bit toggle);
    int v;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (toggle && c <= 11) start = (c % 2 == 0);
      else                   start = 1'b0;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_done"}, {31'd0, done}, (c == 13) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        v = (c - 2) / 3;
        if (v > 3) v = 3;
        check({tag, "_a"}, {30'd0, a1, a2}, 32'(v));
      end
    end
    check({tag, "_err"},  {24'd0, err_count}, 32'(exp_err));
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
    tick();
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_pass"}, {31'd0, pass}, {31'd0, exp_pass});
    check({tag, "_hold_err"},  {24'd0, err_count}, 32'(exp_err));
    check({tag, "_hold_a"},    {30'd0, a1, a2}, 32'd3);
  endtask

  initial begin
    int saw_done;
    int last;
    int k;
    bit exp_done;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err",  {24'd0, err_count}, 32'd0);
    check("rst_a",    {30'd0, a1, a2}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Correct unit
    mode = 0;
    sweep("good", 0, 1'b1, 1'b0);

    // Stuck at 0: only vector 11 mismatches
    mode = 1;
    sweep("stk0", 1, 1'b0, 1'b0);

    // Stuck at 1: vectors 00, 01, 10 mismatch; narrow counters saturate
    mode = 2;
    sweep("stk1", 3, 1'b0, 1'b0);
    check("w2_err",  {30'd0, err_w2}, 32'd3);
    check("w2_pass", {31'd0, pass_w2}, 32'd0);
    check("w1_err",  {31'd0, err_w1}, 32'd1);
    check("w1_pass", {31'd0, pass_w1}, 32'd0);

    // A new start clears err_count and pass
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clr_err",  {24'd0, err_count}, 32'd0);
    check("clr_pass", {31'd0, pass}, 32'd0);
    repeat (6) tick();  // cycle 7 of this sweep
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_a",    {30'd0, a1, a2}, 32'd1);

    // Asynchronous reset mid-sweep
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_a",    {30'd0, a1, a2}, 32'd0);
    check("arst_err",  {24'd0, err_count}, 32'd0);
    check("arst_pass", {31'd0, pass}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (done) saw_done++;
    end
    check("arst_no_done", 32'(saw_done), 32'd0);
    check("arst_idle",    {31'd0, busy}, 32'd0);
    sweep("post_rst", 0, 1'b1, 1'b0);

    // start toggling while busy must not disturb timing
    mode = 1;
    sweep("toggle", 1, 1'b0, 1'b1);

    // start held high over three sweeps
    mode = 1;
    last = 13 + 2 * PERIOD;
    start = 1'b1;
    k = 0;
    for (int c = 1; c <= last + 1; c++) begin
      tick();
      if (c == last) start = 1'b0;
      exp_done = (c >= 13) && ((c - 13) % PERIOD == 0) && (c <= last);
      check("held_done", {31'd0, done}, {31'd0, exp_done});
      if (exp_done) begin
        k++;
`ifdef AND_TESTER_LOOP_EN
        check("held_err", {24'd0, err_count}, 32'(k));
`else
        check("held_err", {24'd0, err_count}, 32'd1);
`endif
        check("held_pass", {31'd0, pass}, 32'd0);
      end
    end
    check("held_sweeps", 32'(k), 32'd3);
    check("held_end_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
